nibble_serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 12 +
 rtl/csa_nibble.sv | 35 +++
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/csa_nibble.sv
// 4-bit carry-select add slice: both ripple chains are evaluated up front and
// the real carry-in only drives the final mux.
module csa_nibble
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [NIBBLE:0]   c0;
  logic [NIBBLE:0]   c1;
  logic [NIBBLE-1:0] s0;
  logic [NIBBLE-1:0] s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < NIBBLE; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[NIBBLE] : c0[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder that walks WIDTH-bit operands through one carry-select
// nibble slice per clock, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int SLICES = WIDTH / NIBBLE;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic [NIBBLE-1:0] slice_sum;
  logic              slice_cout;

  csa_nibble u_slice (
    .a    (a_sh_q[NIBBLE-1:0]),
    .b    (b_sh_q[NIBBLE-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Slice results enter sum_sh at the top, so after SLICES shifts the
  // least-significant nibble has reached bit 0.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_sh_q >> NIBBLE;
        sum_sh_d[WIDTH-1 -: NIBBLE] = slice_sum;
        a_sh_d   = a_sh_q >> NIBBLE;
        b_sh_d   = b_sh_q >> NIBBLE;
        carry_d  = slice_cout;
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = sum_sh_d;
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH 16, 4 and 32, comparing
// every result against plain a+b+cin arithmetic and checking handshake timing.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aBus, bBus;
  logic        cinBus, inValid, outReady;
  int          sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        inReady16, outValid16, busy16, cout16;
  logic [15:0] sum16;
  logic        inReady4, outValid4, busy4, cout4;
  logic [3:0]  sum4;
  logic        inReady32, outValid32, busy32, cout32;
  logic [31:0] sum32;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 0), .in_ready(inReady16),
    .a(aBus[15:0]), .b(bBus[15:0]), .cin(cinBus), .out_valid(outValid16),
    .out_ready(outReady && sel == 0), .sum(sum16), .cout(cout16), .busy(busy16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 1), .in_ready(inReady4),
    .a(aBus[3:0]), .b(bBus[3:0]), .cin(cinBus), .out_valid(outValid4),
    .out_ready(outReady && sel == 1), .sum(sum4), .cout(cout4), .busy(busy4)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid && sel == 2), .in_ready(inReady32),
    .a(aBus), .b(bBus), .cin(cinBus), .out_valid(outValid32),
    .out_ready(outReady && sel == 2), .sum(sum32), .cout(cout32), .busy(busy32)
  );

  logic        inReadyM, outValidM, busyM, coutM;
  logic [31:0] sumM;

  always_comb begin
    inReadyM = inReady16; outValidM = outValid16; busyM = busy16;
    coutM = cout16; sumM = {16'h0, sum16};
    if (sel == 1) begin
      inReadyM = inReady4; outValidM = outValid4; busyM = busy4;
      coutM = cout4; sumM = {28'h0, sum4};
    end else if (sel == 2) begin
      inReadyM = inReady32; outValidM = outValid32; busyM = busy32;
      coutM = cout32; sumM = sum32;
    end
  end

  function automatic int widthOf(input int s);
    return (s == 1) ? 4 : (s == 2) ? 32 : 16;
  endfunction

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic v);
    aBus = av; bBus = bv; cinBus = c; inValid = v;
  endtask

  // One complete operation on the selected instance: accept, count the
  // latency, hold off out_ready for 'stalls' cycles, then complete.
  task automatic runOp(input logic [31:0] av, input logic [31:0] bv, input logic c,
                       input int stalls, input string tag);
    int          w, lat;
    logic [32:0] full;
    logic [31:0] mask, expSum;
    logic        expCout;
    w      = widthOf(sel);
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full   = {1'b0, av & mask} + {1'b0, bv & mask} + {32'h0, c};
    expSum = full[31:0] & mask;
    expCout = full[w];

    @(negedge clk);
    checks++;
    if ({inReadyM, busyM, outValidM} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL %s idle_flags: got %b expected 100", tag, {inReadyM, busyM, outValidM});
    end
    applyStimulus(av, bv, c, 1'b1);
    outReady = 1'($urandom_range(0, 1));
    @(negedge clk);
    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    lat = 0;
    while (outValidM !== 1'b1 && lat < 64) begin
      checks++;
      if ({inReadyM, busyM} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL %s run_flags: got %b expected 01", tag, {inReadyM, busyM});
      end
      lat++;
      outReady = 1'($urandom_range(0, 1));
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    inValid = 1'b0;

    checks++;
    if (lat !== w / 4) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, w / 4);
    end
    checks++;
    if ({sumM, coutM} !== {expSum, expCout}) begin
      errors++;
      $display("[TB] FAIL %s result: got sum=%h cout=%b expected sum=%h cout=%b",
               tag, sumM, coutM, expSum, expCout);
    end

    for (int s = 0; s < stalls; s++) begin
      outReady = 1'b0;
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++;
      if ({outValidM, inReadyM, busyM, sumM, coutM} !== {3'b101, expSum, expCout}) begin
        errors++;
        $display("[TB] FAIL %s stall: got v=%b r=%b busy=%b sum=%h cout=%b expected v=1 r=0 busy=1 sum=%h cout=%b",
                 tag, outValidM, inReadyM, busyM, sumM, coutM, expSum, expCout);
      end
    end

    // New operands offered in the same cycle as the output handshake must be ignored.
    outReady = 1'b1;
    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    @(negedge clk);
    outReady = 1'b0;
    inValid  = 1'b0;
    checks++;
    if ({outValidM, inReadyM, busyM, sumM, coutM} !== {3'b010, expSum, expCout}) begin
      errors++;
      $display("[TB] FAIL %s post_handshake: got v=%b r=%b busy=%b sum=%h cout=%b expected v=0 r=1 busy=0 sum=%h cout=%b",
               tag, outValidM, inReadyM, busyM, sumM, coutM, expSum, expCout);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1);
    outReady = 1'b1;
    #23;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({inReadyM, busyM, outValidM, sumM, coutM} !== {3'b100, 32'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_w%0d: got r=%b busy=%b v=%b sum=%h cout=%b expected r=1 busy=0 v=0 sum=0 cout=0",
                 widthOf(s), inReadyM, busyM, outValidM, sumM, coutM);
      end
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b0;
    rst_n    = 1'b1;
    sel      = 0;
  endtask

  task automatic test_vectors();
    sel = 0;
    runOp(32'h1234, 32'h4321, 1'b0, 0, "vec_1234_4321");
    runOp(32'hFFFF, 32'h0000, 1'b1, 0, "vec_carry_chain");
    runOp(32'h8000, 32'h8000, 1'b0, 0, "vec_msb_overflow");
    runOp(32'h7FFF, 32'h0001, 1'b0, 0, "vec_7fff_plus1");
  endtask

  task automatic test_backpressure();
    sel = 0;
    runOp(32'hABCD, 32'h1111, 1'b1, 5, "backpressure");
  endtask

  task automatic test_reset_midop();
    sel = 0;
    runOp(32'hA5A5, 32'h0F0F, 1'b0, 0, "pre_reset");
    @(negedge clk);
    applyStimulus(32'h1111, 32'h2222, 1'b1, 1'b1);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({inReadyM, busyM, outValidM, sumM, coutM} !== {3'b100, 32'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_midop: got r=%b busy=%b v=%b sum=%h cout=%b expected r=1 busy=0 v=0 sum=0 cout=0",
               inReadyM, busyM, outValidM, sumM, coutM);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({outValidM, busyM} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_no_partial: got v=%b busy=%b expected v=0 busy=0", outValidM, busyM);
      end
    end
    runOp(32'h00FF, 32'h0001, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 1000; n++) begin
        runOp($urandom, $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0, "random");
      end
    end
  endtask

  initial begin
    sel      = 0;
    inValid  = 1'b0;
    outReady = 1'b0;
    aBus     = '0;
    bBus     = '0;
    cinBus   = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
